// File: rtl/ft600_slave_pkg.sv
// Shared types and constants for the FT600 device-side bus emulator.
package ft600_slave_pkg;

  localparam int unsigned C_DW = 16;
  localparam int unsigned C_BW = 2;

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    GAP
  } rx_state_e;

  // Width of a counter that must be able to hold max_val.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ft600_slave_fifo.sv
// First-word-fall-through synchronous FIFO with next-state full/empty flags.
module ft600_slave_fifo #(
  parameter int unsigned AEXP = 10,
  parameter int unsigned W    = 18
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         full_next_o,
  output logic         empty_next_o
);

  localparam int unsigned DEPTH = 1 << AEXP;
  localparam logic [AEXP:0] CNT_FULL = {1'b1, {AEXP{1'b0}}};
  localparam logic [AEXP:0] CNT_ONE  = {{AEXP{1'b0}}, 1'b1};

  logic [W-1:0]    mem_q [DEPTH];
  logic [AEXP-1:0] wptr_q, rptr_q;
  logic [AEXP:0]   cnt_q, cnt_d;
  logic            push_ok, pop_ok;

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop_ok)
      cnt_d = cnt_q + CNT_ONE;
    else if (pop_ok && !push_ok)
      cnt_d = cnt_q - CNT_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AEXP'(1);
      if (pop_ok)  rptr_q <= rptr_q + AEXP'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o      = mem_q[rptr_q];
  assign full_o       = (cnt_q == CNT_FULL);
  assign empty_o      = (cnt_q == '0);
  assign full_next_o  = (cnt_d == CNT_FULL);
  assign empty_next_o = (cnt_d == '0);

endmodule

// File: rtl/ft600_slave_emu.sv
// FT600 device side of the 245 synchronous FIFO bus, with host-side streams
// and an RX burst/gap throttle that mimics chip flow-control stalls.
module ft600_slave_emu
  import ft600_slave_pkg::*;
#(
  parameter int unsigned AEXP       = 10,
  parameter int unsigned BURST_LEN  = 256,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            usb_rxf,
  output logic            usb_txe,
  input  logic            usb_oe,
  input  logic            usb_rd,
  input  logic            usb_wr,
  inout  logic [C_DW-1:0] usb_data,
  inout  logic [C_BW-1:0] usb_be,
  input  logic            host_tx_valid,
  output logic            host_tx_ready,
  input  logic [C_DW-1:0] host_tx_data,
  input  logic [C_BW-1:0] host_tx_be,
  output logic            host_rx_valid,
  input  logic            host_rx_ready,
  output logic [C_DW-1:0] host_rx_data,
  output logic [C_BW-1:0] host_rx_be,
  output logic            err_overrun,
  output logic            err_underrun,
  output logic            err_proto
);

  localparam int unsigned FW     = C_DW + C_BW;
  localparam int unsigned BCNT_W = cnt_w(BURST_LEN);
  localparam int unsigned GCNT_W = cnt_w(GAP_CYCLES);

  logic [FW-1:0] rx_head, tx_head;
  logic rx_full, rx_empty, rx_empty_next, tx_full, tx_empty, tx_full_next;
  logic unused_fifo_flags;
  logic rd_acc, wr_acc, overrun_hit, underrun_hit, proto_hit;

  rx_state_e         state_q, state_d;
  logic [BCNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic [GCNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic rxf_q, txe_q, err_overrun_q, err_underrun_q, err_proto_q;

  assign rd_acc       = !usb_oe && !usb_rd && !rxf_q;
  assign underrun_hit = !usb_rd && rxf_q;
  assign proto_hit    = !usb_wr && !usb_oe;
  assign wr_acc       = !usb_wr && usb_oe && !txe_q;
  assign overrun_hit  = !usb_wr && usb_oe && txe_q;

  ft600_slave_fifo #(.AEXP(AEXP), .W(FW)) u_rx_fifo (
    .clk_i       (clk),
    .rst_ni      (rstn),
    .push_i      (host_tx_valid),
    .wdata_i     ({host_tx_be, host_tx_data}),
    .pop_i       (rd_acc),
    .rdata_o     (rx_head),
    .full_o      (rx_full),
    .empty_o     (rx_empty),
    .full_next_o (),
    .empty_next_o(rx_empty_next)
  );

  ft600_slave_fifo #(.AEXP(AEXP), .W(FW)) u_tx_fifo (
    .clk_i       (clk),
    .rst_ni      (rstn),
    .push_i      (wr_acc),
    .wdata_i     ({usb_be, usb_data}),
    .pop_i       (host_rx_ready),
    .rdata_o     (tx_head),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .full_next_o (tx_full_next),
    .empty_next_o()
  );

  assign unused_fifo_flags = tx_full;

  // A finished gap hands straight to BURST when data waits, so usb_rxf stays
  // high for exactly GAP_CYCLES cycles between bursts.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (!rx_empty) begin
          state_d     = BURST;
          burst_cnt_d = '0;
        end
      end
      BURST: begin
        if (rd_acc) begin
          burst_cnt_d = burst_cnt_q + BCNT_W'(1);
          if (rx_empty_next ||
              (BURST_LEN != 0 && burst_cnt_d == BCNT_W'(BURST_LEN))) begin
            state_d   = GAP;
            gap_cnt_d = '0;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GCNT_W'(GAP_CYCLES - 1)) begin
          if (rx_empty) begin
            state_d = IDLE;
          end else begin
            state_d     = BURST;
            burst_cnt_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GCNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= IDLE;
      burst_cnt_q    <= '0;
      gap_cnt_q      <= '0;
      rxf_q          <= 1'b1;
      txe_q          <= 1'b1;
      err_overrun_q  <= 1'b0;
      err_underrun_q <= 1'b0;
      err_proto_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      burst_cnt_q    <= burst_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      rxf_q          <= (state_d != BURST);
      txe_q          <= tx_full_next;
      err_overrun_q  <= err_overrun_q | overrun_hit;
      err_underrun_q <= err_underrun_q | underrun_hit;
      err_proto_q    <= err_proto_q | proto_hit;
    end
  end

  assign usb_data = (rstn && !usb_oe) ? rx_head[C_DW-1:0] : 'z;
  assign usb_be   = (rstn && !usb_oe) ? rx_head[C_DW +: C_BW] : 'z;

  assign usb_rxf       = rxf_q;
  assign usb_txe       = txe_q;
  assign host_tx_ready = !rx_full;
  assign host_rx_valid = !tx_empty;
  assign host_rx_data  = tx_head[C_DW-1:0];
  assign host_rx_be    = tx_head[C_DW +: C_BW];
  assign err_overrun   = err_overrun_q;
  assign err_underrun  = err_underrun_q;
  assign err_proto     = err_proto_q;

endmodule

// File: tb/tb_ft600_slave_emu.sv
// Directed bench for ft600_slave_emu: reads, burst throttling, write overrun,
// bus contention and mid-transfer reset.
module tb_ft600_slave_emu;

  logic        clk = 1'b0;
  logic        rstn;
  logic        usb_oe, usb_rd, usb_wr;
  wire  [15:0] usb_data;
  wire  [1:0]  usb_be;
  logic        tb_en;
  logic [15:0] tb_data;
  logic [1:0]  tb_be;
  logic        host_tx_valid, host_tx_ready;
  logic [15:0] host_tx_data;
  logic [1:0]  host_tx_be;
  logic        host_rx_valid, host_rx_ready;
  logic [15:0] host_rx_data;
  logic [1:0]  host_rx_be;
  logic        usb_rxf, usb_txe, err_overrun, err_underrun, err_proto;

  int checks = 0;
  int errors = 0;
  int lo_q[$];
  int hi_q[$];

  always #5 clk = ~clk;

  assign usb_data = tb_en ? tb_data : 'z;
  assign usb_be   = tb_en ? tb_be   : 'z;

  ft600_slave_emu #(.AEXP(10), .BURST_LEN(8), .GAP_CYCLES(4)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .usb_rxf      (usb_rxf),
    .usb_txe      (usb_txe),
    .usb_oe       (usb_oe),
    .usb_rd       (usb_rd),
    .usb_wr       (usb_wr),
    .usb_data     (usb_data),
    .usb_be       (usb_be),
    .host_tx_valid(host_tx_valid),
    .host_tx_ready(host_tx_ready),
    .host_tx_data (host_tx_data),
    .host_tx_be   (host_tx_be),
    .host_rx_valid(host_rx_valid),
    .host_rx_ready(host_rx_ready),
    .host_rx_data (host_rx_data),
    .host_rx_be   (host_rx_be),
    .err_overrun  (err_overrun),
    .err_underrun (err_underrun),
    .err_proto    (err_proto)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Host pushes n words (base+i) while a master honouring usb_rxf reads them.
  task automatic rx_stream(input int n, input int base, input int cycles);
    int pushed, got, lo_cur, hi_cur;
    pushed = 0; got = 0; lo_cur = 0; hi_cur = 0;
    lo_q.delete();
    hi_q.delete();
    host_tx_be = 2'b11;
    usb_oe = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      host_tx_valid = (pushed < n);
      host_tx_data  = 16'(base + pushed);
      usb_rd        = usb_rxf;
      #1;
      if (!usb_rxf) begin
        chk("rd_data", {16'h0, usb_data}, 32'(base + got));
        chk("rd_be", {30'h0, usb_be}, 32'd3);
        got++;
        if (hi_cur > 0 && lo_q.size() > 0) hi_q.push_back(hi_cur);
        hi_cur = 0;
        lo_cur++;
      end else begin
        if (lo_cur > 0) lo_q.push_back(lo_cur);
        lo_cur = 0;
        hi_cur++;
      end
      if (host_tx_valid && host_tx_ready) pushed++;
      @(negedge clk);
    end
    if (lo_cur > 0) lo_q.push_back(lo_cur);
    host_tx_valid = 1'b0;
    usb_rd = 1'b1;
    usb_oe = 1'b1;
    chk("rd_count", 32'(got), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0; usb_oe = 1'b1; usb_rd = 1'b1; usb_wr = 1'b1;
    tb_en = 1'b0; tb_data = '0; tb_be = '0;
    host_tx_valid = 1'b0; host_tx_data = '0; host_tx_be = '0; host_rx_ready = 1'b0;

    // Power-on reset state.
    repeat (2) @(negedge clk);
    tb_en = 1'b1;
    #1;
    chk("por_rxf", usb_rxf, 1);
    chk("por_txe", usb_txe, 1);
    chk("por_bus", {16'h0, usb_data}, 0);
    chk("por_rx_valid", host_rx_valid, 0);
    chk("por_tx_ready", host_tx_ready, 1);
    chk("por_errs", {err_overrun, err_underrun, err_proto}, 0);
    tb_en = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Four words read back-to-back, then usb_rxf high.
    rx_stream(4, 1, 20);
    chk("short_lo_runs", 32'(lo_q.size()), 1);
    chk("short_lo0", 32'(lo_q[0]), 4);
    chk("short_hi_runs", 32'(hi_q.size()), 0);
    chk("short_rxf_end", usb_rxf, 1);
    chk("short_underrun", err_underrun, 0);

    // 20 words under an 8-word burst limit with 4-cycle gaps.
    rx_stream(20, 0, 45);
    chk("burst_lo_runs", 32'(lo_q.size()), 3);
    chk("burst_lo0", 32'(lo_q[0]), 8);
    chk("burst_lo1", 32'(lo_q[1]), 8);
    chk("burst_lo2", 32'(lo_q[2]), 4);
    chk("burst_hi_runs", 32'(hi_q.size()), 2);
    chk("burst_hi0", 32'(hi_q[0]), 4);
    chk("burst_hi1", 32'(hi_q[1]), 4);
    chk("burst_underrun", err_underrun, 0);

    // 1027 writes ignoring usb_txe with the host side stalled.
    for (int i = 0; i < 10 && usb_txe; i++) @(negedge clk);
    chk("wr_txe_start", usb_txe, 0);
    for (int i = 0; i < 1027; i++) begin
      chk("wr_txe", usb_txe, (i >= 1024) ? 32'd1 : 32'd0);
      if (i == 1024) chk("wr_overrun_pre", err_overrun, 0);
      tb_en = 1'b1; tb_data = 16'(i); tb_be = 2'b11; usb_wr = 1'b0;
      @(negedge clk);
    end
    usb_wr = 1'b1; tb_en = 1'b0;
    chk("wr_overrun", err_overrun, 1);
    chk("wr_proto", err_proto, 0);
    host_rx_ready = 1'b1;
    for (int j = 0; j < 1024; j++) begin
      chk("drain_valid", host_rx_valid, 1);
      chk("drain_data", {16'h0, host_rx_data}, 32'(j));
      chk("drain_be", {30'h0, host_rx_be}, 3);
      @(negedge clk);
    end
    chk("drain_empty", host_rx_valid, 0);
    chk("drain_txe", usb_txe, 0);

    // be=00 word is stored and forwarded untouched.
    host_rx_ready = 1'b0;
    tb_en = 1'b1; tb_data = 16'h1234; tb_be = 2'b00; usb_wr = 1'b0;
    @(negedge clk);
    usb_wr = 1'b1; tb_en = 1'b0;
    chk("be0_valid", host_rx_valid, 1);
    chk("be0_data", {16'h0, host_rx_data}, 32'h1234);
    chk("be0_be", {30'h0, host_rx_be}, 0);
    host_rx_ready = 1'b1;
    @(negedge clk);
    chk("be0_drained", host_rx_valid, 0);

    // Write while output enable is asserted: contention, word dropped.
    host_rx_ready = 1'b0;
    chk("proto_pre", err_proto, 0);
    usb_oe = 1'b0; usb_wr = 1'b0;
    tb_en = 1'b1; tb_data = 16'hBEEF; tb_be = 2'b11;
    @(negedge clk);
    usb_wr = 1'b1; tb_en = 1'b0; usb_oe = 1'b1;
    repeat (2) @(negedge clk);
    chk("proto_flag", err_proto, 1);
    chk("proto_dropped", host_rx_valid, 0);
    chk("proto_underrun", err_underrun, 0);

    // Reset in the middle of a 10-word read burst with TX data pending.
    tb_en = 1'b1; tb_data = 16'h0AA0; tb_be = 2'b11;
    for (int i = 0; i < 2; i++) begin
      usb_wr = 1'b0;
      @(negedge clk);
    end
    usb_wr = 1'b1; tb_en = 1'b0;
    chk("mid_tx_pending", host_rx_valid, 1);
    host_tx_be = 2'b11;
    for (int i = 0; i < 10; i++) begin
      host_tx_valid = 1'b1; host_tx_data = 16'(16'h0100 + i);
      @(negedge clk);
    end
    host_tx_valid = 1'b0;
    chk("mid_rxf", usb_rxf, 0);
    usb_oe = 1'b0; usb_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mid_rd_data", {16'h0, usb_data}, 32'(16'h0100 + i));
      @(negedge clk);
    end
    #2;
    rstn = 1'b0;
    tb_en = 1'b1; tb_data = 16'h0000; tb_be = 2'b00;
    #1;
    chk("rst_rxf", usb_rxf, 1);
    chk("rst_txe", usb_txe, 1);
    chk("rst_bus_data", {16'h0, usb_data}, 0);
    chk("rst_bus_be", {30'h0, usb_be}, 0);
    chk("rst_rx_valid", host_rx_valid, 0);
    chk("rst_tx_ready", host_tx_ready, 1);
    chk("rst_errs", {err_overrun, err_underrun, err_proto}, 0);
    tb_en = 1'b0; usb_rd = 1'b1; usb_oe = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("post_rst_rxf", usb_rxf, 1);
    chk("post_rst_rx_valid", host_rx_valid, 0);
    chk("post_rst_txe", usb_txe, 0);

    // Single word into an empty FIFO: usb_rxf low after the second edge.
    host_tx_valid = 1'b1; host_tx_data = 16'h00AA; host_tx_be = 2'b11;
    @(negedge clk);
    host_tx_valid = 1'b0;
    chk("lat_rxf_n", usb_rxf, 1);
    @(negedge clk);
    chk("lat_rxf_n1", usb_rxf, 0);
    usb_oe = 1'b0;
    #1;
    chk("aa_data", {16'h0, usb_data}, 32'h00AA);
    usb_rd = 1'b0;
    @(negedge clk);
    usb_rd = 1'b1; usb_oe = 1'b1;
    chk("aa_rxf_after", usb_rxf, 1);
    chk("aa_underrun", err_underrun, 0);
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
